axi_id_killer_rd: RTL
=====================

AXI_ID_KILLER_RD -- requirements
Module: axi_id_killer_rd

Interface
REQ-001 Parameters (name, default, meaning): ID_WIDTH, 4, upstream AXI ID width; ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, read data width; MAX_OUTSTANDING, 8, maximum in-flight read bursts (must be >=1 and <= ID FIFO depth).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
REQ-003 Upstream AR ports (name, direction, width, meaning):
- s_arvalid/s_arready  in/out  1/1  upstream AR handshake.
- s_arid  in  ID_WIDTH  upstream transaction ID.
- s_araddr/s_arlen/s_arsize/s_arburst  in  ADDR_WIDTH/8/3/2  AR payload.
REQ-004 Downstream AR ports, ID-less:
- m_arvalid/m_arready  out/in  1/1  downstream AR handshake.
- m_araddr/m_arlen/m_arsize/m_arburst  out  ADDR_WIDTH/8/3/2  registered AR payload.
REQ-005 Downstream R ports, single-ID and in-order:
- m_rvalid/m_rready  in/out  1/1  downstream R handshake.
- m_rdata/m_rresp/m_rlast  in  DATA_WIDTH/2/1  R payload.
REQ-006 Upstream R ports:
- s_rvalid/s_rready  out/in  1/1  upstream R handshake.
- s_rid/s_rdata/s_rresp/s_rlast  out  ID_WIDTH/DATA_WIDTH/2/1  registered R beat with restored ID.
REQ-007 ID FIFO ports, connecting to the external ID FIFO (registered full/empty flags, combinational read data):
- fifo_winc/fifo_wfull/fifo_wdata  out/in/out  1/1/ID_WIDTH  push side.
- fifo_rinc/fifo_rempty/fifo_rdata  out/in/in  1/1/ID_WIDTH  pop side.
REQ-008 Status port:
- err_unexpected  out  1  sticky flag, R beat arrived with no recorded ID.

Function
REQ-009 The block SHALL hold an outstanding counter cnt of width clog2(MAX_OUTSTANDING+1).
REQ-010 s_arready SHALL equal (!m_arvalid || m_arready) && !fifo_wfull && cnt != MAX_OUTSTANDING.
REQ-011 On an upstream AR handshake, the AR payload SHALL load into the m_ar* register and m_arvalid SHALL be 1 on the next cycle. AR latency is exactly 1 cycle.
REQ-012 On an upstream AR handshake, fifo_winc SHALL be 1 and fifo_wdata SHALL be s_arid in that same cycle. fifo_winc SHALL be 0 otherwise.
REQ-013 m_arvalid SHALL clear after a downstream handshake unless a new upstream handshake occurs in the same cycle. m_ar* SHALL be stable while m_arvalid && !m_arready.
REQ-014 m_rready SHALL equal !s_rvalid || s_rready.
REQ-015 On a downstream R handshake, the beat SHALL load into the s_r* register, with s_rid = fifo_rdata, and s_rvalid SHALL be 1 on the next cycle. R latency is exactly 1 cycle.
REQ-016 fifo_rinc SHALL be 1 only on a downstream R handshake with m_rlast=1 and fifo_rempty=0. Non-last beats SHALL NOT pop.
REQ-017 cnt SHALL increment on an upstream AR handshake and decrement on a downstream R handshake with m_rlast=1. If both occur in the same cycle, cnt SHALL be unchanged. cnt SHALL never wrap.
REQ-018 A downstream R handshake while fifo_rempty=1 SHALL:
- set err_unexpected to 1 (sticky until rst);
- forward the beat with s_rid=0;
- leave cnt and the FIFO unchanged.
REQ-019 While s_rvalid && !s_rready, s_r* SHALL be stable.
REQ-020 Return order SHALL equal AR issue order, with IDs restored in FIFO order.

Reset
REQ-021 While rst=1, the block SHALL hold s_arready=0, m_arvalid=0, s_rvalid=0, fifo_winc=0, fifo_rinc=0, cnt=0 and err_unexpected=0.
REQ-022 Payload registers need no reset.
REQ-023 Assertion of rst mid-burst SHALL discard all in-flight state. The external FIFO SHALL be reset by the same rst.
REQ-024 After rst deasserts, m_rready SHALL be 1 on the first cycle.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single burst: AR id=5, arlen=3 -> m_ar* one cycle later; 4 R beats with s_rid=5; fifo_rinc once on the last beat; cnt 0->1->0.
- Interleaved IDs: AR ids 3,7,1 back-to-back; in-order downstream bursts -> s_rid sequence 3,7,1; err_unexpected stays 0.
- Limit: MAX_OUTSTANDING=2, three AR without R -> third stalls (s_arready=0) until the first rlast handshake; then it is accepted the next cycle.
- Backpressure: s_rready=0 for 5 cycles mid-burst -> m_rready=0 after the register fills; no beat lost or duplicated; payload stable.
- Simultaneous AR accept and rlast handshake at cnt=1 -> cnt stays 1; one FIFO push and one pop occur in the same cycle.
- Unexpected R: m_rvalid with the FIFO empty -> beat forwarded with s_rid=0; err_unexpected=1 until rst; rst mid-burst -> all valids 0 and cnt=0 the next cycle.

Source files
------------

// File: rtl/axi_id_killer_rd.sv
// Read-channel AXI ID stripper: forwards AR without ID, records IDs in an external FIFO,
// and restores them on the in-order R stream. Unrecorded R beats are flagged and passed with ID 0.
module axi_id_killer_rd #(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,

    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,

    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,

    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,

    output logic                  fifo_winc,
    input  logic                  fifo_wfull,
    output logic [ID_WIDTH-1:0]   fifo_wdata,
    output logic                  fifo_rinc,
    input  logic                  fifo_rempty,
    input  logic [ID_WIDTH-1:0]   fifo_rdata,

    output logic                  err_unexpected
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt;
    logic          ar_hs;
    logic          r_hs;
    logic          r_last_hs;

    // Handshakes are gated by rst so nothing moves while the block is held in reset.
    assign s_arready  = !rst && (!m_arvalid || m_arready) && !fifo_wfull && (cnt != CNT_MAX);
    assign ar_hs      = s_arvalid && s_arready;
    assign m_rready   = !s_rvalid || s_rready;
    assign r_hs       = !rst && m_rvalid && m_rready;
    assign r_last_hs  = r_hs && m_rlast && !fifo_rempty;

    assign fifo_winc  = ar_hs;
    assign fifo_wdata = s_arid;
    assign fifo_rinc  = r_last_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_arvalid      <= 1'b0;
            s_rvalid       <= 1'b0;
            cnt            <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (ar_hs)
                m_arvalid <= 1'b1;
            else if (m_arready)
                m_arvalid <= 1'b0;

            if (r_hs)
                s_rvalid <= 1'b1;
            else if (s_rready)
                s_rvalid <= 1'b0;

            if (r_hs && fifo_rempty)
                err_unexpected <= 1'b1;

            if (ar_hs && !r_last_hs && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            else if (r_last_hs && !ar_hs && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // Payload registers only load on a handshake, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            m_araddr  <= s_araddr;
            m_arlen   <= s_arlen;
            m_arsize  <= s_arsize;
            m_arburst <= s_arburst;
        end
        if (r_hs) begin
            s_rid   <= fifo_rempty ? '0 : fifo_rdata;
            s_rdata <= m_rdata;
            s_rresp <= m_rresp;
            s_rlast <= m_rlast;
        end
    end

endmodule
